display_sel_ctrl: RTL
=====================

DISPLAY_SEL_CTRL -- requirements
Module: display_sel_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 10: idle ticks before an edit/alarm view returns to time view; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tick, input, 1, 2 Hz enable pulse, high for exactly one clk cycle.
REQ-005 SHALL have port mode_btn, input, 1, debounced single-cycle mode pulse.
REQ-006 SHALL have port inc_btn, input, 1, debounced single-cycle increment pulse.
REQ-007 SHALL have port alarm_ring, input, 1, level; high while the alarm is sounding.
REQ-008 SHALL have port sel, output, 1, select for the 16-bit display mux: 1 = clock time (a), 0 = alarm time (b).
REQ-009 SHALL have port blank, output, 1, display blanking for the field being edited.
REQ-010 SHALL have port inc_hr, output, 1, one-cycle pulse commanding an alarm-hour increment.
REQ-011 SHALL have port inc_min, output, 1, one-cycle pulse commanding an alarm-minute increment.
REQ-012 SHALL have port state, output, 2, current state encoding for debug.

Function
REQ-013 SHALL implement states SHOW_TIME=0, SHOW_ALARM=1, SET_HR=2, SET_MIN=3.
REQ-014 SHALL advance on mode_btn: SHOW_TIME->SHOW_ALARM->SET_HR->SET_MIN->SHOW_TIME, one step per pulse.
REQ-015 SHALL force SHOW_TIME on the next edge whenever alarm_ring=1, taking priority over mode_btn, inc_btn and timeout.
REQ-016 SHALL ignore mode_btn and inc_btn while alarm_ring=1.
REQ-017 SHALL drive sel=1 in SHOW_TIME and sel=0 in all other states, decoded from the state register with no extra latency.
REQ-018 SHALL keep an idle counter of width ceil(log2(TIMEOUT+1)), cleared on any mode_btn or inc_btn pulse and on every state change.
REQ-019 SHALL increment the idle counter on tick in states other than SHOW_TIME; it saturates and never wraps.
REQ-020 SHALL return to SHOW_TIME on the edge where the counter would reach TIMEOUT; the counter is held at 0 in SHOW_TIME.
REQ-021 SHALL give a button pulse coincident with tick priority: counter cleared to 0, no increment.
REQ-022 SHALL keep a blink flag toggled on each tick in SET_HR/SET_MIN, cleared on state entry and on inc_btn; blank = blink flag in SET_HR/SET_MIN, else 0.
REQ-023 SHALL register inc_hr=1 for exactly one cycle, on the edge after inc_btn, when in SET_HR; inc_min behaves the same way in SET_MIN; both are 0 otherwise.
REQ-024 SHALL produce at most one inc pulse per inc_btn pulse; inc_btn in SHOW_TIME/SHOW_ALARM has no effect except clearing the counter.
REQ-025 SHALL give mode_btn and inc_btn in the same cycle this result: mode transition taken, inc ignored.

Reset
REQ-026 SHALL on rst=1 immediately set state=SHOW_TIME, sel=1, blank=0, inc_hr=0, inc_min=0, idle counter=0, blink flag=0, with no clock required.
REQ-027 SHALL on reset assertion mid-edit abort any pending inc pulse; operation resumes in SHOW_TIME on the first edge after rst falls.

Verification
REQ-028 SHALL cover reset during SET_MIN with blank=1: assert rst -> state=0, sel=1, blank=0 before the next clk edge.
REQ-029 SHALL cover four mode_btn pulses from reset: state sequence 1,2,3,0; sel sequence 0,0,0,1.
REQ-030 SHALL cover the timeout case: enter SET_HR, 9 ticks then 10th tick with TIMEOUT=10 -> state=0 after the 10th tick edge; an inc_btn after tick 5 delays return to tick 15.
REQ-031 SHALL cover increments: inc_btn in SET_HR -> inc_hr=1 for one cycle, inc_min=0, blank=0; the same in SET_MIN -> inc_min pulse only.
REQ-032 SHALL cover the alarm case: alarm_ring=1 in SET_MIN together with a mode_btn pulse -> state=0, sel=1, no inc pulse; mode_btn ignored until alarm_ring=0.
REQ-033 SHALL cover blinking: 4 ticks in SET_HR with no buttons -> blank sequence 1,0,1,0; inc_btn clears blank to 0.

Source files
------------

// File: rtl/display_sel_ctrl.sv
// Display select / edit controller for an alarm clock: chooses time or alarm view,
// drives edit-field blanking and alarm hour/minute increment pulses.
module display_sel_ctrl #(
  parameter int unsigned TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_ring,
  output logic       sel,
  output logic       blank,
  output logic       inc_hr,
  output logic       inc_min,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] SHOW_TIME  = 2'd0;
  localparam logic [1:0] SHOW_ALARM = 2'd1;
  localparam logic [1:0] SET_HR     = 2'd2;
  localparam logic [1:0] SET_MIN    = 2'd3;

  localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT);

  logic [1:0]    state_next;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] idle_next;
  logic [CW:0]   idle_inc;
  logic          blink;
  logic          blink_next;
  logic          mode;
  logic          inc;
  logic          expire;
  logic          changed;
  logic          editing_next;

  always_comb begin
    // The ringing alarm masks both buttons entirely.
    mode     = mode_btn & ~alarm_ring;
    inc      = inc_btn & ~alarm_ring;
    idle_inc = {1'b0, idle_cnt} + (CW + 1)'(1);
    // A button coincident with tick clears the counter, so it can never expire then.
    expire   = (state != SHOW_TIME) & tick & ~mode & ~inc & (idle_inc == LIMIT);

    state_next = state;
    if (alarm_ring) begin
      state_next = SHOW_TIME;
    end else if (mode) begin
      state_next = state + 2'd1;
    end else if (expire) begin
      state_next = SHOW_TIME;
    end

    changed      = (state_next != state);
    editing_next = (state_next == SET_HR) || (state_next == SET_MIN);

    idle_next = idle_cnt;
    if (changed || (state_next == SHOW_TIME) || mode || inc) begin
      idle_next = '0;
    end else if (tick && (idle_cnt != LIMIT[CW-1:0])) begin
      idle_next = idle_inc[CW-1:0];
    end

    blink_next = blink;
    if (changed || !editing_next || inc) begin
      blink_next = 1'b0;
    end else if (tick) begin
      blink_next = ~blink;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SHOW_TIME;
      idle_cnt <= '0;
      blink    <= 1'b0;
      inc_hr   <= 1'b0;
      inc_min  <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_next;
      blink    <= blink_next;
      inc_hr   <= inc & ~mode & (state == SET_HR);
      inc_min  <= inc & ~mode & (state == SET_MIN);
    end
  end

  assign sel   = (state == SHOW_TIME);
  assign blank = blink & ((state == SET_HR) || (state == SET_MIN));

endmodule
